// File: rtl/seq_approx_mult_ctrl.sv
// Iterative shift-and-add multiplier sharing one adder across all partial products.
// The low APPROX_BITS accumulator columns are merged with OR and never carry upward.
module seq_approx_mult_ctrl #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    // Shift by PW yields an all-zero mask, so APPROX_BITS=0 is an exact add.
    localparam logic [PW-1:0] LOW_MASK = {PW{1'b1}} >> (PW - APPROX_BITS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   sum_hi;
    logic [PW-1:0]   sum_lo;
    logic [PW-1:0]   acc_step;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            accept;

    always_comb begin
        sum_hi   = (acc & ~LOW_MASK) + (mcand & ~LOW_MASK);
        sum_lo   = (acc | mcand) & LOW_MASK;
        acc_step = mplier[0] ? (sum_hi | sum_lo) : acc;
    end

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = start & ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ready     = 1'b1;
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                product <= acc_step;
            end
        end
    end

endmodule

// File: doc/seq_approx_mult_ctrl.md
# seq_approx_mult_ctrl

Sequential controller that time-shares one adder across all partial products of a WIDTH×WIDTH unsigned multiply. It runs one shift-and-add step per cycle. The low APPROX_BITS accumulator columns are combined carry-free (bitwise OR), mirroring the approximate-compressor behaviour of the multiplier array. The block sits between a requester issuing start/operand handshakes and the downstream consumer of the 2·WIDTH-bit product. It serves as the area-reduced, iterative alternative to the parallel compressor tree.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- APPROX_BITS, 4, number of low accumulator columns summed by OR without carry (0 = exact; ≤2·WIDTH)
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; accepted on a rising edge where start=1 and ready=1
- a  in  WIDTH  multiplicand, sampled only on acceptance
- b  in  WIDTH  multiplier, sampled only on acceptance
- ready  out  1  high in IDLE and DONE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, high in DONE
- product  out  2·WIDTH  registered result, held until the next completion

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: on start=1 → RUN. Load mcand ← zero-extended a (2·WIDTH bits), mplier ← b, acc ← 0, cnt ← 0.
- RUN, each cycle:
  - if mplier[0], acc ← approx_add(acc, mcand)
  - mcand ← mcand<<1; mplier ← mplier>>1; cnt ← cnt+1
  - after the step with cnt = WIDTH−1: product ← final acc value, → DONE
  - no early termination; start is ignored in RUN.
- DONE: done=1 for exactly one cycle.
  - start=1 → RUN with new operands, loaded as in IDLE (back-to-back issue).
  - otherwise → IDLE.
- approx_add(x,y), K=APPROX_BITS:
  - result[K−1:0] = x[K−1:0] | y[K−1:0]
  - result[2W−1:K] = x[2W−1:K] + y[2W−1:K], truncated to 2W−K bits
  - no carry crosses from column K−1 into K.
  - With K=0 this is an exact 2W-bit add, and the result equals a·b exactly.
- The exact product fits in 2·WIDTH bits, so no overflow is possible when K=0. With K>0 the upper-field sum is truncated; the result is never wider than 2·WIDTH.
- Reset mid-operation: the next rising edge with rst_n=0 aborts RUN or DONE. It forces IDLE and clears acc, cnt and product to 0. No done pulse is produced for the aborted request.

## Timing
- Reset values: ready=1, busy=0, done=0, product=0. Internal acc/mcand/mplier/cnt=0.
- Acceptance edge = E0. busy=1 during cycles after E0 through E0+WIDTH.
- done=1 in the cycle after edge E0+WIDTH. product is updated on that same edge.
- Latency from acceptance to done is WIDTH+1 edges; that is 9 cycles for WIDTH=8.
- Throughput with back-to-back start is one result per WIDTH+1 cycles.
- product changes only on the RUN→DONE edge or on reset. Between completions it is stable regardless of start, a or b.
- a/b may change freely after acceptance.
- ready, busy and done are mutually consistent: exactly one of IDLE/RUN/DONE is active. busy=1 implies ready=0; done=1 implies ready=1.

## Test plan
- Reset with rst_n=0 for 2 cycles → ready=1, busy=0, done=0, product=0. With start=1 held during reset, no acceptance occurs.
- WIDTH=8, K=0: a=255, b=255, start pulse → done after 9 cycles, product=65025. a=200, b=100 → 20000. a=0, b=77 → 0.
- WIDTH=8, K=4: a=3, b=3 → product=7 (exact 9; low-column OR). a=16, b=16 → 256 (no overlap, exact).
- Back-to-back: start held high. (a=3,b=3) then (a=16,b=16) with K=4 → done pulses exactly 9 cycles apart with products 7 then 256. Start during RUN is ignored and operands applied during RUN have no effect.
- Reset mid-run: accept a=255, b=255 (K=0) and drive rst_n=0 at the 4th RUN cycle → next cycle IDLE, product=0, no done pulse. A fresh request then completes normally with 65025.
- Hold: after a completion with product=20000, toggle a/b with start=0 for 20 cycles → product remains 20000, done stays 0.
